pipe_scheduler: RTL and testbench



---
 rtl/flappy_pkg.sv | 17 +
 rtl/pipe_scheduler_if.sv | 28 ++
 rtl/lfsr10.sv | 16 +
 rtl/pipe_scheduler.sv | 138 +++++++++++++
 tb/tb_pipe_scheduler.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// Shared types and default parameters for the pipe scheduler slice.
package flappy_pkg;

  // Game FSM encoding; values are visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int         DEF_NUM_PIPES = 3;
  localparam int         DEF_TICK_DIV  = 4;
  localparam int         DEF_SPAWN_GAP = 213;
  localparam logic [9:0] DEF_LFSR_SEED = 10'h2A5;
  localparam int         SCORE_W       = 8;

endpackage

// File: rtl/pipe_scheduler_if.sv
// Player/pipe-slot signal bundle between the scheduler and the game datapath.
interface pipe_scheduler_if import flappy_pkg::*; #(
  parameter int NUM_PIPES = DEF_NUM_PIPES
) ();

  logic                 btn;
  logic                 collision;
  logic [NUM_PIPES-1:0] slot_done;
  logic [NUM_PIPES-1:0] slot_start;
  logic [NUM_PIPES-1:0] slot_reset;
  logic [9:0]           pipe_length;
  logic [SCORE_W-1:0]   score;
  logic                 game_over;
  logic [1:0]           state;

  // Scheduler side.
  modport master (
    input  btn, collision, slot_done,
    output slot_start, slot_reset, pipe_length, score, game_over, state
  );

  // Game / pipe-instance side.
  modport slave (
    output btn, collision, slot_done,
    input  slot_start, slot_reset, pipe_length, score, game_over, state
  );

endinterface

// File: rtl/lfsr10.sv
// 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1, maximal length (1023).
module lfsr10 #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] q
);

  // Free-running shift every clock; a nonzero seed keeps it off the lock-up state.
  always_ff @(posedge clk) begin
    if (reset) q <= SEED;
    else       q <= {q[8:0], q[9] ^ q[6]};
  end

endmodule

// File: rtl/pipe_scheduler.sv
// Game-flow FSM plus pipe-slot allocator: paces movement ticks, spawns pipes
// into the lowest free slot every SPAWN_GAP ticks, and keeps the score.
module pipe_scheduler import flappy_pkg::*; #(
  parameter int         NUM_PIPES = DEF_NUM_PIPES,
  parameter int         TICK_DIV  = DEF_TICK_DIV,
  parameter int         SPAWN_GAP = DEF_SPAWN_GAP,
  parameter logic [9:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic           clk,
  input  logic           reset,
  pipe_scheduler_if.master bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SPAWN_GAP + 1);

  state_t               state_q, state_d;
  logic                 btn_q;
  logic                 btn_rise;
  logic                 go_run;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic [SW-1:0]        spawn_cnt;
  logic                 spawn;
  logic [NUM_PIPES-1:0] active_q;
  logic [NUM_PIPES-1:0] free;
  logic [NUM_PIPES-1:0] spawn_oh;
  logic [NUM_PIPES-1:0] done_v;
  logic [NUM_PIPES-1:0] slot_reset_q;
  logic [SCORE_W-1:0]   score_q;
  logic                 game_over_q;
  logic [9:0]           lfsr_q;

  function automatic logic [SCORE_W-1:0] count_ones(input logic [NUM_PIPES-1:0] v);
    logic [SCORE_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_PIPES; i++) n = n + SCORE_W'(v[i]);
    return n;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  assign btn_rise = bus.btn & ~btn_q;
  assign go_run   = (state_q == ST_IDLE) && (state_d == ST_RUN);
  assign tick     = (state_q == ST_RUN) && (tick_cnt == TW'(TICK_DIV - 1));
  // Only pulses that hit a live slot count; stray pulses are dropped.
  assign done_v   = bus.slot_done & active_q;
  // Eligibility uses registered active, so a slot freed this cycle waits a cycle.
  assign free     = ~active_q;
  assign spawn_oh = free & (~free + NUM_PIPES'(1));
  assign spawn    = (state_q == ST_RUN) && (spawn_cnt == SW'(SPAWN_GAP)) && (|free);

  // Next-state logic; collision has priority over a button edge in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (btn_rise)      state_d = ST_RUN;
      ST_RUN:  if (bus.collision) state_d = ST_OVER;
      ST_OVER: if (btn_rise)      state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Button history; resets high so a held button does not look like a press.
  always_ff @(posedge clk) begin
    if (reset) btn_q <= 1'b1;
    else       btn_q <= bus.btn;
  end

  // Movement tick divider, parked at zero whenever not staying in RUN.
  always_ff @(posedge clk) begin
    if (reset || state_q != ST_RUN || state_d != ST_RUN) tick_cnt <= '0;
    else if (tick)                                       tick_cnt <= '0;
    else                                                 tick_cnt <= tick_cnt + TW'(1);
  end

  // Spawn gap counter: preset on game start for an immediate first spawn,
  // saturates at the gap so a deferred spawn fires as soon as a slot frees.
  always_ff @(posedge clk) begin
    if (reset) spawn_cnt <= '0;
    else if (go_run) spawn_cnt <= SW'(SPAWN_GAP);
    else if (state_q == ST_RUN) begin
      if (spawn)                                         spawn_cnt <= '0;
      else if (tick && spawn_cnt != SW'(SPAWN_GAP))      spawn_cnt <= spawn_cnt + SW'(1);
    end
  end

  // Slot occupancy, one-cycle slot resets, and held-in-IDLE resets.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q     <= '0;
      slot_reset_q <= '1;
    end else if (state_d == ST_IDLE) begin
      active_q     <= '0;
      slot_reset_q <= '1;
    end else begin
      active_q     <= (active_q & ~done_v) | (spawn ? spawn_oh : '0);
      slot_reset_q <= done_v;
    end
  end

  // Score and game-over flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      if (go_run)                 score_q <= '0;
      else if (state_q == ST_RUN) score_q <= sat_add(score_q, count_ones(done_v));
      game_over_q <= (state_d == ST_OVER);
    end
  end

  lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign bus.slot_start  = {NUM_PIPES{tick}} & active_q;
  assign bus.slot_reset  = slot_reset_q;
  assign bus.pipe_length = lfsr_q;
  assign bus.score       = score_q;
  assign bus.game_over   = game_over_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler with NUM_PIPES=2, TICK_DIV=2, SPAWN_GAP=4.
module tb_pipe_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  pipe_scheduler_if #(.NUM_PIPES(2)) bus ();

  pipe_scheduler #(
    .NUM_PIPES (2),
    .TICK_DIV  (2),
    .SPAWN_GAP (4),
    .LFSR_SEED (10'h2A5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       btn;
    logic       col;
    logic [1:0] done;
    logic [1:0] st;
    logic [7:0] score;
    logic [1:0] start;
    logic [1:0] sreset;
    logic       go;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add(input logic rst, input logic btn, input logic col, input logic [1:0] done,
                     input logic [1:0] st, input logic [7:0] score, input logic [1:0] start,
                     input logic [1:0] sreset, input logic go);
    vec_t v;
    v.rst = rst; v.btn = btn; v.col = col; v.done = done;
    v.st = st; v.score = score; v.start = start; v.sreset = sreset; v.go = go;
    vecs.push_back(v);
  endtask

  task automatic check_row(input int idx, input vec_t v);
    logic [14:0] act, req;
    act = {bus.state, bus.score, bus.slot_start, bus.slot_reset, bus.game_over};
    req = {v.st, v.score, v.start, v.sreset, v.go};
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL row%0d: state=%0d score=%0d start=%b sreset=%b go=%b required state=%0d score=%0d start=%b sreset=%b go=%b",
               idx, bus.state, bus.score, bus.slot_start, bus.slot_reset, bus.game_over,
               v.st, v.score, v.start, v.sreset, v.go);
    end
  endtask

  task automatic wait_start(input int b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.slot_start[b]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    bit ok;
    bit nz;

    reset = 1'b1;
    bus.btn = 1'b1;
    bus.collision = 1'b0;
    bus.slot_done = 2'b00;

    // rst btn col done | state score start sreset go
    add(1, 1, 0, 2'b00, 2'd0, 8'd0, 2'b00, 2'b11, 0); // reset, button held
    add(0, 1, 1, 2'b00, 2'd0, 8'd0, 2'b00, 2'b11, 0); // held btn: no edge; collision ignored
    add(0, 0, 0, 2'b11, 2'd0, 8'd0, 2'b00, 2'b11, 0); // done in IDLE ignored
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b00, 2'b00, 0); // edge -> first RUN cycle
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b01, 2'b00, 0); // R1 slot0 live, tick
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b00, 2'b00, 0); // R2
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b01, 2'b00, 0); // R3
    add(0, 1, 0, 2'b10, 2'd1, 8'd0, 2'b00, 2'b00, 0); // R4 done on idle slot1 ignored
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b01, 2'b00, 0); // R5
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b00, 2'b00, 0); // R6
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b01, 2'b00, 0); // R7 tick 4
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b00, 2'b00, 0); // R8 spawn slot1
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b11, 2'b00, 0); // R9 both live
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b00, 2'b00, 0); // R10
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b11, 2'b00, 0); // R11
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b00, 2'b00, 0); // R12
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b11, 2'b00, 0); // R13
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b00, 2'b00, 0); // R14
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b11, 2'b00, 0); // R15 gap reached, no free slot
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b00, 2'b00, 0); // R16
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b11, 2'b00, 0); // R17
    add(0, 1, 0, 2'b00, 2'd1, 8'd0, 2'b00, 2'b00, 0); // R18
    add(0, 1, 0, 2'b01, 2'd1, 8'd1, 2'b10, 2'b01, 0); // R19 slot0 done -> reset pulse
    add(0, 1, 0, 2'b00, 2'd1, 8'd1, 2'b00, 2'b00, 0); // R20 slot0 respawned
    add(0, 1, 0, 2'b00, 2'd1, 8'd1, 2'b11, 2'b00, 0); // R21

    foreach (vecs[i]) begin
      reset         = vecs[i].rst;
      bus.btn       = vecs[i].btn;
      bus.collision = vecs[i].col;
      bus.slot_done = vecs[i].done;
      step();
      check_row(i, vecs[i]);
    end

    // Drive score up to 254 by holding done high on every live slot.
    bus.slot_done = 2'b11;
    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      step();
      if (bus.score == 8'd254) found = 1'b1;
    end
    check("reach_254", found, 1'b1);
    bus.slot_done = 2'b00;

    wait_start(1, ok);
    check("wait_both", ok, 1'b1);
    check("both_active", bus.slot_start, 2'b11);
    bus.slot_done = 2'b11;
    step();
    check("sat_255", bus.score, 8'd255);
    check("sat_slot_reset", bus.slot_reset, 2'b11);
    bus.slot_done = 2'b00;
    step();
    check("slot_reset_one_cycle", bus.slot_reset, 2'b00);
    wait_start(0, ok);
    check("wait_respawn", ok, 1'b1);
    bus.slot_done = 2'b01;
    step();
    check("sat_hold", bus.score, 8'd255);
    bus.slot_done = 2'b00;

    // Reset in the middle of RUN while a done pulse arrives.
    wait_start(0, ok);
    check("wait_live_before_reset", ok, 1'b1);
    reset = 1'b1;
    bus.slot_done = 2'b01;
    step();
    check("rst_state", bus.state, 2'd0);
    check("rst_score", bus.score, 8'd0);
    check("rst_slot_reset", bus.slot_reset, 2'b11);
    check("rst_game_over", bus.game_over, 1'b0);
    reset = 1'b0;
    bus.slot_done = 2'b00;

    // New game: only slot0 may come up, proving active was cleared.
    bus.btn = 1'b0;
    step();
    bus.btn = 1'b1;
    step();
    check("restart_run", bus.state, 2'd1);
    check("restart_score", bus.score, 8'd0);
    step();
    check("restart_active", bus.slot_start, 2'b01);
    bus.slot_done = 2'b01;
    step();
    check("score_one", bus.score, 8'd1);
    bus.slot_done = 2'b00;
    bus.btn = 1'b0;
    step();

    // Collision and button edge together: collision wins.
    bus.collision = 1'b1;
    bus.btn = 1'b1;
    step();
    check("over_state", bus.state, 2'd2);
    check("over_flag", bus.game_over, 1'b1);
    check("over_score", bus.score, 8'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("over_frozen", {bus.state, bus.slot_start}, {2'd2, 2'b00});
    end
    bus.collision = 1'b0;
    bus.btn = 1'b0;
    step();
    bus.btn = 1'b1;
    step();
    check("idle_state", bus.state, 2'd0);
    check("idle_slot_reset", bus.slot_reset, 2'b11);
    check("idle_game_over", bus.game_over, 1'b0);
    check("idle_score_held", bus.score, 8'd1);

    // LFSR period and nonzero property.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("lfsr_seed", bus.pipe_length, 10'h2A5);
    step();
    check("lfsr_second", bus.pipe_length, 10'h14B);
    nz = (bus.pipe_length != 10'd0);
    for (int i = 0; i < 1022; i++) begin
      step();
      if (bus.pipe_length == 10'd0) nz = 1'b0;
    end
    check("lfsr_period", bus.pipe_length, 10'h2A5);
    check("lfsr_nonzero", nz, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
